// File: rtl/mb_arb_pkg.sv
// mb_arb_pkg: shared constants, tag type and 3*my helper for the multiplier arbiter
package mb_arb_pkg;
  localparam int WIDTH = 8;
  localparam int NREQ = 4;
  localparam int LAT = 4;
  localparam int RDEPTH = 2;
  localparam int ID_W = $clog2(NREQ);
  localparam int CRED_W = $clog2(RDEPTH + 1);
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
  } tag_t;
  function automatic logic [WIDTH+1:0] tmy3(input logic [WIDTH-1:0] my);
    return {2'b00, my} + {1'b0, my, 1'b0};
  endfunction
endpackage

// File: rtl/mb_rsp_fifo.sv
// mb_rsp_fifo: per-requester response FIFO; head shown on dout, zero when empty
module mb_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic pop;
  assign valid = cnt != '0;
  assign pop = valid & ready;
  assign dout = valid ? mem[rd] : '0;
  always_ff @(posedge CLK)
    if (push) mem[wr] <= din;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // Credits make a push into a full, non-draining FIFO impossible
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && !pop && cnt == CW'(DEPTH)));
endmodule

// File: rtl/mb_mul_arbiter.sv
// mb_mul_arbiter: round-robin, credit-gated sharing of one fixed-latency pipelined multiplier
module mb_mul_arbiter
  import mb_arb_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_mx,
  input  logic [NREQ*WIDTH-1:0]   req_my,
  output logic [WIDTH-1:0]        mul_mx,
  output logic [WIDTH-1:0]        mul_my,
  output logic [WIDTH+1:0]        mul_tmy,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [NREQ*2*WIDTH-1:0] rsp_product,
  output logic                    busy
);
  logic [WIDTH-1:0] mx_a [NREQ];
  logic [WIDTH-1:0] my_a [NREQ];
  logic [CRED_W-1:0] credit [NREQ];
  logic [NREQ-1:0] elig, pop;
  logic [ID_W-1:0] ptr, gid, j;
  logic found;
  tag_t tags [LAT+1];
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign mx_a[i] = req_mx[i*WIDTH +: WIDTH];
    assign my_a[i] = req_my[i*WIDTH +: WIDTH];
    assign elig[i] = req_valid[i] & (credit[i] != '0);
    assign pop[i] = rsp_valid[i] & rsp_ready[i];
    mb_rsp_fifo #(.DEPTH(RDEPTH), .W(2*WIDTH)) u_fifo (
      .CLK(CLK),
      .RST(RST),
      .push(tags[LAT].valid && tags[LAT].id == ID_W'(i)),
      .din(mul_product),
      .ready(rsp_ready[i]),
      .valid(rsp_valid[i]),
      .dout(rsp_product[i*2*WIDTH +: 2*WIDTH])
    );
  end
  always_comb begin
    found = 1'b0;
    gid = '0;
    j = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && elig[j]) begin
        found = 1'b1;
        gid = j;
      end
    end
  end
  assign req_ready = found ? NREQ'(1) << gid : '0;
  // tags[0] rides alongside the issue register; tags[LAT] lines up with mul_product
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ptr <= ID_W'(NREQ - 1);
      mul_mx <= '0;
      mul_my <= '0;
      mul_tmy <= '0;
      for (int k = 0; k < NREQ; k++) credit[k] <= CRED_W'(RDEPTH);
      for (int k = 0; k <= LAT; k++) tags[k] <= '0;
    end else begin
      if (found) ptr <= gid;
      mul_mx <= found ? mx_a[gid] : '0;
      mul_my <= found ? my_a[gid] : '0;
      mul_tmy <= found ? tmy3(my_a[gid]) : '0;
      for (int k = 0; k < NREQ; k++) credit[k] <= credit[k] - CRED_W'(req_ready[k]) + CRED_W'(pop[k]);
      tags[0] <= '{valid: found, id: gid};
      for (int k = 1; k <= LAT; k++) tags[k] <= tags[k-1];
    end
  always_comb begin
    busy = |rsp_valid;
    for (int k = 0; k <= LAT; k++) busy = busy | tags[k].valid;
  end
endmodule

// File: tb/tb_mb_mul_arbiter.sv
// tb_mb_mul_arbiter: scoreboard bench with a delay-line multiplier model and a round-robin/credit reference
module tb_mb_mul_arbiter;
  import mb_arb_pkg::*;
  logic CLK = 0;
  logic RST = 1;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*WIDTH-1:0] req_mx, req_my;
  logic [WIDTH-1:0] mul_mx, mul_my;
  logic [WIDTH+1:0] mul_tmy;
  logic [2*WIDTH-1:0] mul_product;
  logic [NREQ*2*WIDTH-1:0] rsp_product;
  logic busy;
  logic [2*WIDTH-1:0] mpipe [LAT];
  logic [2*WIDTH-1:0] exp_q [NREQ][$];
  int ptr_m = NREQ - 1;
  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  mb_mul_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mx(req_mx), .req_my(req_my),
    .mul_mx(mul_mx), .mul_my(mul_my), .mul_tmy(mul_tmy), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .busy(busy)
  );

  // Multiplier model: product of operands seen in cycle k appears in cycle k+LAT
  assign mul_product = mpipe[LAT-1];
  always @(posedge CLK) begin
    mpipe[0] <= 16'(mul_mx) * 16'(mul_my);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: outstanding ops per requester = queue length; credit = RDEPTH - length
  always @(negedge CLK) begin
    int eg, out, j;
    if (RST) begin
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
      ptr_m = NREQ - 1;
    end else begin
      out = 0;
      for (int i = 0; i < NREQ; i++) out += exp_q[i].size();
      chk("busy", 32'(busy), 32'(out != 0));
      eg = -1;
      for (int k = 1; k <= NREQ; k++) begin
        j = (ptr_m + k) % NREQ;
        if (eg < 0 && req_valid[j] && exp_q[j].size() < RDEPTH) eg = j;
      end
      chk("grant", 32'(req_ready), eg < 0 ? 0 : 1 << eg);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && exp_q[i].size() == 0) chk($sformatf("rsp%0d_spurious", i), 32'(rsp_valid[i]), 0);
        else if (rsp_valid[i] && rsp_ready[i]) chk($sformatf("rsp%0d_product", i), 32'(rsp_product[i*2*WIDTH +: 2*WIDTH]), 32'(exp_q[i].pop_front()));
        else if (!rsp_valid[i]) chk($sformatf("rsp%0d_idle_zero", i), 32'(rsp_product[i*2*WIDTH +: 2*WIDTH]), 0);
      end
      if (eg >= 0) begin
        exp_q[eg].push_back(16'(req_mx[eg*WIDTH +: WIDTH]) * 16'(req_my[eg*WIDTH +: WIDTH]));
        ptr_m = eg;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n;
    step();
    req_valid = '0;
    rsp_ready = '1;
    n = 0;
    @(negedge CLK);
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 32'(busy), 0);
  endtask

  initial begin
    int n, c1;
    int cnt [NREQ];
    req_valid = '0;
    rsp_ready = '1;
    req_mx = '0;
    req_my = '0;
    @(negedge CLK);
    chk("rst_mul_mx", 32'(mul_mx), 0);
    chk("rst_mul_my", 32'(mul_my), 0);
    chk("rst_mul_tmy", 32'(mul_tmy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_product", 32'(rsp_product), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    RST = 0;
    // Single request timing
    step();
    req_mx[7:0] = 8'h0F;
    req_my[7:0] = 8'h11;
    req_valid = 4'b0001;
    @(negedge CLK);
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("single_grant", 32'(req_ready[0]), 1);
    step();
    req_valid = '0;
    @(negedge CLK);
    chk("single_mul_mx", 32'(mul_mx), 32'h0F);
    chk("single_mul_my", 32'(mul_my), 32'h11);
    chk("single_mul_tmy", 32'(mul_tmy), 32'h033);
    for (int k = 2; k <= 5; k++) begin
      @(negedge CLK);
      chk("single_early_rsp", 32'(rsp_valid[0]), 0);
    end
    @(negedge CLK);
    chk("single_rsp_valid", 32'(rsp_valid[0]), 1);
    chk("single_rsp_product", 32'(rsp_product[15:0]), 32'h00FF);
    drain();
    // All four valid: strict rotation, one issue per cycle
    step();
    req_mx = {8'h80, 8'hFF, 8'h10, 8'h02};
    req_my = {8'h80, 8'hFF, 8'h10, 8'h03};
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk("rr_order", 32'(req_ready), 1 << ((k + 1) % 4));
    end
    drain();
    // Backpressure on requester 1
    step();
    rsp_ready = 4'b1101;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
      step();
      req_mx = NREQ*WIDTH'($urandom);
      req_my = NREQ*WIDTH'($urandom);
    end
    chk("bp_req1_accepts", cnt[1], 2);
    chk("bp_req0_served", 32'(cnt[0] >= 4), 1);
    chk("bp_req2_served", 32'(cnt[2] >= 4), 1);
    chk("bp_req3_served", 32'(cnt[3] >= 4), 1);
    rsp_ready[1] = 1'b1;
    step();
    rsp_ready[1] = 1'b0;
    c1 = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (req_ready[1]) c1++;
    end
    chk("bp_one_more", c1, 1);
    drain();
    // Grant and pop in the same cycle at credit 1
    step();
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    req_mx = NREQ*WIDTH'($urandom);
    req_my = NREQ*WIDTH'($urandom);
    @(negedge CLK);
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    step();
    req_valid = '0;
    @(negedge CLK);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("gp_fifo_filled", 32'(rsp_valid[0]), 1);
    step();
    req_valid = 4'b0001;
    rsp_ready[0] = 1'b1;
    req_mx = NREQ*WIDTH'($urandom);
    req_my = NREQ*WIDTH'($urandom);
    @(negedge CLK);
    chk("gp_grant", 32'(req_ready[0]), 1);
    chk("gp_pop", 32'(rsp_valid[0]), 1);
    step();
    rsp_ready[0] = 1'b0;
    req_mx = NREQ*WIDTH'($urandom);
    req_my = NREQ*WIDTH'($urandom);
    c1 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (req_ready[0]) c1++;
    end
    chk("gp_credit_kept", c1, 1);
    drain();
    // Reset mid-flight
    step();
    req_valid = '1;
    repeat (3) step();
    req_valid = '0;
    step();
    RST = 1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    step();
    RST = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    step();
    req_valid = '1;
    @(negedge CLK);
    chk("midrst_first_grant", 32'(req_ready), 1);
    drain();
    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step();
      req_mx = NREQ*WIDTH'($urandom);
      req_my = NREQ*WIDTH'($urandom);
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom);
    end
    drain();
    n = 0;
    for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
    chk("final_all_delivered", n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
